// File: rtl/clock_lcd_pkg.sv
// Shared definitions for the clock LCD writer.
// Holds the FSM state types, the HD44780 command bytes, the weekday name
// table, the default timing constants, and helpers that turn the shadowed
// time fields into the bytes the LCD receives.
package clock_lcd_pkg;

    localparam int DEF_POWER_UP_CYCLES = 1_080_000;  // 20 ms at 54 MHz
    localparam int DEF_EN_CYCLES       = 27;         // 500 ns
    localparam int DEF_CMD_CYCLES      = 2_700;      // 50 us
    localparam int DEF_CLEAR_CYCLES    = 108_000;    // 2 ms

    localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
    localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_LINE1      = 8'h80;
    localparam logic [7:0] CMD_LINE2      = 8'hC0;

    localparam logic [3:0] INIT_LAST_IDX  = 4'd3;
    localparam logic [3:0] FRAME_LAST_IDX = 4'd12;

    // Element 0 is the leftmost string, so index == day_cnt.
    localparam logic [0:7][23:0] DAY_NAMES =
        {"SUN", "MON", "TUE", "WED", "THU", "FRI", "SAT", "---"};

    typedef enum logic [1:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_FRAME
    } lcd_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_EN,
        TX_WAIT
    } tx_state_t;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = CMD_FUNC_SET;
            2'd1:    b = CMD_DISP_ON;
            2'd2:    b = CMD_ENTRY_MODE;
            default: b = CMD_CLEAR;
        endcase
        return b;
    endfunction

    // Two ASCII decimal digits, no clamping: 63 stays "63".
    function automatic logic [15:0] ascii_2dig(input logic [5:0] v);
        logic [5:0] tens;
        logic [5:0] ones;
        tens = v / 6'd10;
        ones = v % 6'd10;
        return {8'h30 + {2'b00, tens}, 8'h30 + {2'b00, ones}};
    endfunction

    // Returns {rs, data} for byte idx of the 13-byte frame.
    function automatic logic [8:0] frame_byte(input logic [3:0] idx,
                                              input logic [4:0] hour,
                                              input logic [5:0] min,
                                              input logic [5:0] sec,
                                              input logic [2:0] day);
        logic [15:0] hh;
        logic [15:0] mm;
        logic [15:0] ss;
        logic [23:0] dn;
        logic [8:0]  b;
        hh = ascii_2dig({1'b0, hour});
        mm = ascii_2dig(min);
        ss = ascii_2dig(sec);
        dn = DAY_NAMES[day];
        case (idx)
            4'd0:    b = {1'b0, CMD_LINE1};
            4'd1:    b = {1'b1, hh[15:8]};
            4'd2:    b = {1'b1, hh[7:0]};
            4'd3:    b = {1'b1, 8'h3A};
            4'd4:    b = {1'b1, mm[15:8]};
            4'd5:    b = {1'b1, mm[7:0]};
            4'd6:    b = {1'b1, 8'h3A};
            4'd7:    b = {1'b1, ss[15:8]};
            4'd8:    b = {1'b1, ss[7:0]};
            4'd9:    b = {1'b0, CMD_LINE2};
            4'd10:   b = {1'b1, dn[23:16]};
            4'd11:   b = {1'b1, dn[15:8]};
            4'd12:   b = {1'b1, dn[7:0]};
            default: b = {1'b0, 8'h00};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// One-byte HD44780 sender.
// A start in TX_IDLE latches rs/data, which then stay stable for the whole
// byte: one setup cycle, EN_CYCLES of en high, then the post-byte wait
// (CLEAR_CYCLES after command 0x01, otherwise CMD_CYCLES).
// Ports: clk, reset (sync, active high); i_start/i_rs/i_data request;
//        o_ready (idle), o_done (last wait cycle);
//        o_lcd_rs/o_lcd_en/o_lcd_data drive the LCD bus.
//
// state    | meaning
// TX_IDLE  | waiting for start, en low
// TX_SETUP | rs/data presented, en low for one cycle
// TX_EN    | en high, counting EN_CYCLES
// TX_WAIT  | en low, counting post-byte wait; done on terminal count
module lcd_byte_tx
    import clock_lcd_pkg::*;
#(
    parameter int EN_CYCLES    = DEF_EN_CYCLES,
    parameter int CMD_CYCLES   = DEF_CMD_CYCLES,
    parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_done,
    output logic       o_lcd_rs,
    output logic       o_lcd_en,
    output logic [7:0] o_lcd_data
);

    localparam int MAX_A      = (EN_CYCLES > CMD_CYCLES) ? EN_CYCLES : CMD_CYCLES;
    localparam int MAX_CYCLES = (MAX_A > CLEAR_CYCLES) ? MAX_A : CLEAR_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] EN_LOAD    = CW'(EN_CYCLES - 1);
    localparam logic [CW-1:0] CMD_LOAD   = CW'(CMD_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);

    tx_state_t     r_state;
    tx_state_t     w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_rs;
    logic [7:0]    r_data;
    logic          w_is_clear;

    assign w_is_clear = !r_rs && (r_data == CMD_CLEAR);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            TX_IDLE: begin
                if (i_start) w_state_next = TX_SETUP;
            end
            TX_SETUP: begin
                w_state_next = TX_EN;
                w_cnt_next   = EN_LOAD;
            end
            TX_EN: begin
                if (r_cnt == '0) begin
                    w_state_next = TX_WAIT;
                    w_cnt_next   = w_is_clear ? CLEAR_LOAD : CMD_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            TX_WAIT: begin
                if (r_cnt == '0) w_state_next = TX_IDLE;
                else             w_cnt_next   = r_cnt - 1'b1;
            end
            default: w_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (r_state == TX_IDLE && i_start) begin
                r_rs   <= i_rs;
                r_data <= i_data;
            end
        end
    end

    assign o_ready    = (r_state == TX_IDLE);
    assign o_done     = (r_state == TX_WAIT) && (r_cnt == '0);
    assign o_lcd_en   = (r_state == TX_EN);
    assign o_lcd_rs   = r_rs;
    assign o_lcd_data = r_data;

endmodule

// File: rtl/clock_lcd_writer.sv
// Clock display writer for an HD44780 in 8-bit mode.
// After a power-up hold it sends the init commands, then redraws
// "HH:MM:SS" on line 1 and the weekday on line 2 whenever the time inputs
// differ from the last drawn values. Frames are built only from shadow
// registers, so input changes during a frame are picked up afterwards.
// Ports: clk, reset (sync, active high); sec/min/hour/day_cnt time inputs;
//        lcd_rs/lcd_rw/lcd_en/lcd_data LCD bus; busy (not IDLE);
//        init_done (init sequence finished).
//
// state       | meaning
// ST_PWR_WAIT | power-up hold, no strobes
// ST_INIT     | sending 0x38, 0x0C, 0x06, 0x01
// ST_IDLE     | comparing inputs with shadows
// ST_FRAME    | sending the 13-byte frame from shadows
module clock_lcd_writer
    import clock_lcd_pkg::*;
#(
    parameter int POWER_UP_CYCLES = DEF_POWER_UP_CYCLES,
    parameter int EN_CYCLES       = DEF_EN_CYCLES,
    parameter int CMD_CYCLES      = DEF_CMD_CYCLES,
    parameter int CLEAR_CYCLES    = DEF_CLEAR_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    input  logic [2:0] day_cnt,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       init_done
);

    localparam int            PW      = $clog2(POWER_UP_CYCLES + 1);
    localparam logic [PW-1:0] PW_LOAD = PW'(POWER_UP_CYCLES - 1);

    lcd_state_t    r_state;
    lcd_state_t    w_state_next;
    logic [PW-1:0] r_pw_cnt;
    logic [3:0]    r_idx;
    logic          r_issue;      // current byte still has to be handed to the sender
    logic          r_init_done;
    logic          r_first;      // forces one frame after init
    logic [4:0]    r_sh_hour;
    logic [5:0]    r_sh_min;
    logic [5:0]    r_sh_sec;
    logic [2:0]    r_sh_day;

    logic          w_start;
    logic          w_load_shadow;
    logic          w_changed;
    logic          w_tx_ready;
    logic          w_tx_done;
    logic [8:0]    w_byte;

    assign w_changed = {hour, min, sec, day_cnt} !=
                       {r_sh_hour, r_sh_min, r_sh_sec, r_sh_day};

    assign w_byte = (r_state == ST_INIT)
                  ? {1'b0, init_byte(r_idx[1:0])}
                  : frame_byte(r_idx, r_sh_hour, r_sh_min, r_sh_sec, r_sh_day);

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_PWR_WAIT;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_start       = 1'b0;
        w_load_shadow = 1'b0;
        case (r_state)
            ST_PWR_WAIT: begin
                if (r_pw_cnt == '0) w_state_next = ST_INIT;
            end
            ST_INIT: begin
                w_start = r_issue && w_tx_ready;
                if (w_tx_done && r_idx == INIT_LAST_IDX) w_state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (r_first || w_changed) begin
                    w_load_shadow = 1'b1;
                    w_state_next  = ST_FRAME;
                end
            end
            ST_FRAME: begin
                w_start = r_issue && w_tx_ready;
                if (w_tx_done && r_idx == FRAME_LAST_IDX) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pw_cnt    <= PW_LOAD;
            r_idx       <= 4'd0;
            r_issue     <= 1'b0;
            r_init_done <= 1'b0;
            r_first     <= 1'b1;
            r_sh_hour   <= '0;
            r_sh_min    <= '0;
            r_sh_sec    <= '0;
            r_sh_day    <= '0;
        end else begin
            if (w_start) r_issue <= 1'b0;
            case (r_state)
                ST_PWR_WAIT: begin
                    if (r_pw_cnt != '0) begin
                        r_pw_cnt <= r_pw_cnt - 1'b1;
                    end else begin
                        r_idx   <= 4'd0;
                        r_issue <= 1'b1;
                    end
                end
                ST_INIT, ST_FRAME: begin
                    if (w_tx_done) begin
                        if (w_state_next == ST_IDLE) begin
                            if (r_state == ST_INIT) r_init_done <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_issue <= 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (w_load_shadow) begin
                        r_sh_hour <= hour;
                        r_sh_min  <= min;
                        r_sh_sec  <= sec;
                        r_sh_day  <= day_cnt;
                        r_first   <= 1'b0;
                        r_idx     <= 4'd0;
                        r_issue   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    lcd_byte_tx #(
        .EN_CYCLES   (EN_CYCLES),
        .CMD_CYCLES  (CMD_CYCLES),
        .CLEAR_CYCLES(CLEAR_CYCLES)
    ) u_byte_tx (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_start),
        .i_rs      (w_byte[8]),
        .i_data    (w_byte[7:0]),
        .o_ready   (w_tx_ready),
        .o_done    (w_tx_done),
        .o_lcd_rs  (lcd_rs),
        .o_lcd_en  (lcd_en),
        .o_lcd_data(lcd_data)
    );

    assign lcd_rw    = 1'b0;
    assign busy      = (r_state != ST_IDLE);
    assign init_done = r_init_done;

endmodule

// File: tb/tb_clock_lcd_writer.sv
module tb_clock_lcd_writer;

    localparam int POWER_UP = 10;
    localparam int EN_W     = 2;
    localparam int CMD_W    = 4;
    localparam int CLEAR_W  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [2:0] day_cnt;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;
    logic       busy;
    logic       init_done;

    clock_lcd_writer #(
        .POWER_UP_CYCLES(POWER_UP),
        .EN_CYCLES      (EN_W),
        .CMD_CYCLES     (CMD_W),
        .CLEAR_CYCLES   (CLEAR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .day_cnt  (day_cnt),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .lcd_data (lcd_data),
        .busy     (busy),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int starts = 0;
    int last_fall_cyc = 0;
    int rw_bad = 0;
    bit abort_pulse = 1'b0;
    logic [8:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
    endtask

    task automatic push_frame(input string hms, input string day);
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, hms[i]});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, day[i]});
    endtask

    // Monitor: one record per en pulse, checked against the scoreboard.
    bit         m_prev_en = 1'b0;
    logic       m_prev_rs = 1'b0;
    logic [7:0] m_prev_data = 8'h00;
    bit         m_in = 1'b0;
    logic       m_rs;
    logic [7:0] m_data;
    int         m_width;
    bit         m_unstable;
    bit         m_setup_ok;
    logic [8:0] m_exp;

    always @(negedge clk) begin
        if (lcd_rw !== 1'b0) rw_bad++;
        if (lcd_en === 1'b1 && !m_prev_en) begin
            starts++;
            m_in       = 1'b1;
            m_rs       = lcd_rs;
            m_data     = lcd_data;
            m_width    = 1;
            m_unstable = 1'b0;
            m_setup_ok = (m_prev_rs === lcd_rs) && (m_prev_data === lcd_data);
        end else if (lcd_en === 1'b1 && m_in) begin
            m_width++;
            if ({lcd_rs, lcd_data} !== {m_rs, m_data}) m_unstable = 1'b1;
        end else if (lcd_en !== 1'b1 && m_in) begin
            m_in = 1'b0;
            last_fall_cyc = cyc;
            if (abort_pulse) begin
                abort_pulse = 1'b0;
            end else if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: got rs=%0d data=%02h, none expected", m_rs, m_data);
            end else begin
                m_exp = exp_q.pop_front();
                check("byte_rs_data", 32'({m_rs, m_data}), 32'(m_exp));
                check("en_width", 32'(m_width), 32'(EN_W));
                check("setup_cycle", 32'(m_setup_ok), 32'd1);
                check("stable_in_pulse", 32'(m_unstable), 32'd0);
            end
        end
        m_prev_en   = (lcd_en === 1'b1);
        m_prev_rs   = lcd_rs;
        m_prev_data = lcd_data;
    end

    // Caller has raised reset so that the next posedge samples it.
    task automatic reset_and_init(input string tag);
        int n;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check({tag, "_rst_en"},   32'(lcd_en),    32'd0);
        check({tag, "_rst_rs"},   32'(lcd_rs),    32'd0);
        check({tag, "_rst_data"}, 32'(lcd_data),  32'd0);
        check({tag, "_rst_busy"}, 32'(busy),      32'd1);
        check({tag, "_rst_init"}, 32'(init_done), 32'd0);
        n = 0;
        while (lcd_en !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        // PWR_WAIT counted from the reset cycle, then one issue and one setup cycle.
        check({tag, "_first_en_delay"}, 32'(n), 32'(POWER_UP + 2));
        n = 0;
        while (init_done !== 1'b1 && n < 500) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_init_done_seen"}, 32'(init_done === 1'b1), 32'd1);
        check({tag, "_init_done_delay"}, 32'(cyc - last_fall_cyc), 32'd8);
        check({tag, "_idle_at_init_done"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_frame_done(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && busy === 1'b0) && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_done"}, 32'(exp_q.size() == 0 && busy === 1'b0), 32'd1);
    endtask

    task automatic hold_quiet(input int ncyc, input string tag);
        int s0;
        int bad;
        s0 = starts;
        bad = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (busy !== 1'b0) bad++;
        end
        check({tag, "_busy_low"}, 32'(bad), 32'd0);
        check({tag, "_no_en"}, 32'(starts - s0), 32'd0);
    endtask

    task automatic wait_starts(input int target, input string tag);
        int n;
        n = 0;
        while (starts < target && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_reached"}, 32'(starts >= target), 32'd1);
    endtask

    task automatic wait_en(input logic v, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (lcd_en !== v && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_en_level"}, 32'(lcd_en), 32'(v));
    endtask

    initial begin
        int base;
        hour = 5'd13; min = 6'd5; sec = 6'd9; day_cnt = 3'd2;
        reset = 1'b1;
        push_init();
        push_frame("13:05:09", "TUE");
        reset_and_init("por");
        wait_frame_done("first_frame");
        hold_quiet(200, "hold");

        // sec changes during byte 3: old frame completes, then a fresh one.
        base = starts;
        @(posedge clk);
        #1 min = 6'd6;
        push_frame("13:06:09", "TUE");
        wait_starts(base + 3, "mid_change");
        sec = 6'd10;
        push_frame("13:06:10", "TUE");
        wait_frame_done("change_frames");
        hold_quiet(30, "after_change");

        @(posedge clk);
        #1 hour = 5'd31; min = 6'd63; sec = 6'd0; day_cnt = 3'd7;
        push_frame("31:63:00", "---");
        wait_frame_done("max_fields");
        hold_quiet(30, "after_max");

        // Reset while en is high in the middle of a frame.
        base = starts;
        @(posedge clk);
        #1 sec = 6'd1;
        push_frame("31:63:01", "---");
        wait_starts(base + 4, "pre_abort");
        wait_en(1'b0, "pre_abort_low");
        wait_en(1'b1, "abort_high");
        abort_pulse = 1'b1;
        reset = 1'b1;
        exp_q.delete();
        push_init();
        push_frame("31:63:01", "---");
        reset_and_init("mid_reset");
        wait_frame_done("post_reset_frame");
        hold_quiet(30, "after_reset");

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("rw_always_low", 32'(rw_bad), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
